// File: rtl/viterbi_bmu_soft.sv
// Pipelined soft/hard branch-metric unit: per-symbol distances in stage 1,
// adder tree onto the hypothesis metrics in stage 2, plus per-frame counters.

module bmu_sym_dist #(
    parameter int SOFT_W = 3,
    parameter int HARD   = 0
) (
    input  logic [SOFT_W-1:0] sym,
    input  logic              erase,
    output logic [SOFT_W-1:0] d0,
    output logic [SOFT_W-1:0] d1
);
    localparam logic [SOFT_W-1:0] SMAX = '1;

    always_comb begin
        d0 = '0;
        d1 = '0;
        if (!erase) begin
            if (HARD != 0) begin
                d0 = SOFT_W'(sym[SOFT_W-1]);
                d1 = SOFT_W'(!sym[SOFT_W-1]);
            end else begin
                d0 = sym;
                d1 = SMAX - sym;
            end
        end
    end
endmodule

module viterbi_bmu_soft #(
    parameter  int N_OUT    = 2,
    parameter  int SOFT_W   = 3,
    parameter  int HARD     = 0,
    localparam int METRIC_W = SOFT_W + $clog2(N_OUT),
    localparam int N_HYP    = 2 ** N_OUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_OUT*SOFT_W-1:0]   in_sym,
    input  logic [N_OUT-1:0]          in_erase,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_HYP*METRIC_W-1:0] out_bm,
    output logic                      out_last,
    output logic [15:0]               sym_count,
    output logic [15:0]               erase_count
);
    logic [N_OUT-1:0][SOFT_W-1:0]   d0_c, d1_c, d0_d, d1_d, d0_q, d1_q;
    logic [N_HYP-1:0][METRIC_W-1:0] bm_c, out_bm_d, out_bm_q;
    logic s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
    logic out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic [15:0] sym_count_d, sym_count_q, erase_count_d, erase_count_q;
    logic [15:0] sym_base, erase_base;
    logic [16:0] erase_sum;
    logic        clr_d, clr_q;
    logic        adv1, adv2, accept;

    for (genvar i = 0; i < N_OUT; i++) begin : g_sym
        bmu_sym_dist #(.SOFT_W(SOFT_W), .HARD(HARD)) u_dist (
            .sym   (in_sym[i*SOFT_W +: SOFT_W]),
            .erase (in_erase[i]),
            .d0    (d0_c[i]),
            .d1    (d1_c[i])
        );
    end

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && !rst;
    assign accept   = in_valid && in_ready;

    // Hypothesis bit i selects which stored distance symbol i contributes.
    always_comb begin
        bm_c = '0;
        for (int h = 0; h < N_HYP; h++) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (((h >> i) & 1) != 0) bm_c[h] = bm_c[h] + METRIC_W'(d1_q[i]);
                else                     bm_c[h] = bm_c[h] + METRIC_W'(d0_q[i]);
            end
        end
    end

    always_comb begin
        s1_valid_d  = adv1 ? accept : s1_valid_q;
        d0_d        = accept ? d0_c : d0_q;
        d1_d        = accept ? d1_c : d1_q;
        s1_last_d   = accept ? in_last : s1_last_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_bm_d    = (adv2 && s1_valid_q) ? bm_c : out_bm_q;
        out_last_d  = (adv2 && s1_valid_q) ? s1_last_q : out_last_q;
    end

    // The count of a finished frame stays visible for one cycle, then clears;
    // an accept in that clearing cycle starts the new frame from zero.
    always_comb begin
        sym_base      = clr_q ? 16'd0 : sym_count_q;
        erase_base    = clr_q ? 16'd0 : erase_count_q;
        erase_sum     = {1'b0, erase_base};
        sym_count_d   = sym_base;
        erase_count_d = erase_base;
        clr_d         = 1'b0;
        if (accept) begin
            for (int i = 0; i < N_OUT; i++) erase_sum = erase_sum + 17'(in_erase[i]);
            sym_count_d   = (sym_base == 16'hFFFF) ? 16'hFFFF : sym_base + 16'd1;
            erase_count_d = erase_sum[16] ? 16'hFFFF : erase_sum[15:0];
            clr_d         = in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            d0_q          <= '0;
            d1_q          <= '0;
            s1_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_bm_q      <= '0;
            out_last_q    <= 1'b0;
            sym_count_q   <= '0;
            erase_count_q <= '0;
            clr_q         <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            d0_q          <= d0_d;
            d1_q          <= d1_d;
            s1_last_q     <= s1_last_d;
            out_valid_q   <= out_valid_d;
            out_bm_q      <= out_bm_d;
            out_last_q    <= out_last_d;
            sym_count_q   <= sym_count_d;
            erase_count_q <= erase_count_d;
            clr_q         <= clr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bm      = out_bm_q;
    assign out_last    = out_last_q;
    assign sym_count   = sym_count_q;
    assign erase_count = erase_count_q;
endmodule

// File: tb/tb_viterbi_bmu_soft.sv
// Scoreboard bench: a soft and a hard instance share stimulus; a monitor pops
// model-predicted metrics on every output transfer.

module tb_viterbi_bmu_soft;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [5:0]  in_sym = '0;
    logic [1:0]  in_erase = '0;
    logic        in_ready_s, in_ready_h, out_valid_s, out_valid_h, out_last_s, out_last_h;
    logic [15:0] bm_s, bm_h, sc_s, ec_s, sc_h, ec_h;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic [15:0] bm; logic last;} exp_t;
    exp_t q_s[$];
    exp_t q_h[$];
    int  exp_sym = 0, exp_er = 0;
    bit  clr_pend = 1'b0;

    viterbi_bmu_soft #(.N_OUT(2), .SOFT_W(3), .HARD(0)) u_soft (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_sym(in_sym),
        .in_erase(in_erase), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_bm(bm_s), .out_last(out_last_s), .sym_count(sc_s), .erase_count(ec_s));

    viterbi_bmu_soft #(.N_OUT(2), .SOFT_W(3), .HARD(1)) u_hard (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .in_sym(in_sym),
        .in_erase(in_erase), .in_last(in_last), .out_valid(out_valid_h), .out_ready(out_ready),
        .out_bm(bm_h), .out_last(out_last_h), .sym_count(sc_h), .erase_count(ec_h));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference metric: sum over symbols of the distance to the hypothesised bit.
    function automatic logic [15:0] ref_bm(input logic [5:0] s, input logic [1:0] e, input bit hard);
        logic [15:0] r;
        int sum, d, sv, hb;
        r = '0;
        for (int h = 0; h < 4; h++) begin
            sum = 0;
            for (int i = 0; i < 2; i++) begin
                sv = (int'(s) >> (3 * i)) & 7;
                hb = (h >> i) & 1;
                if (e[i]) d = 0;
                else if (hard) d = ((sv >> 2) & 1) ^ hb;
                else d = (hb != 0) ? 7 - sv : sv;
                sum += d;
            end
            r[h*4 +: 4] = sum[3:0];
        end
        return r;
    endfunction

    task automatic step(input bit v, input logic [5:0] s, input logic [1:0] e, input bit l,
                        input bit rdy, output bit acc, output bit rdy_seen);
        exp_t x;
        @(posedge clk); #1;
        chk("sym_count", sc_s, exp_sym);
        chk("erase_count", ec_s, exp_er);
        chk("sym_count_hard", sc_h, exp_sym);
        in_valid = v; in_sym = s; in_erase = e; in_last = l; out_ready = rdy;
        @(negedge clk);
        rdy_seen = in_ready_s;
        acc = v && in_ready_s;
        if (clr_pend) begin exp_sym = 0; exp_er = 0; clr_pend = 1'b0; end
        if (acc) begin
            exp_sym++;
            exp_er += int'(e[0]) + int'(e[1]);
            clr_pend = l;
            x.bm = ref_bm(s, e, 1'b0); x.last = l; q_s.push_back(x);
            x.bm = ref_bm(s, e, 1'b1); q_h.push_back(x);
        end
    endtask

    // Monitor: compare on each transfer, and require stable outputs while stalled.
    initial begin
        bit stall [2];
        logic [15:0] prev_bm [2];
        logic prev_last [2];
        logic v, l;
        logic [15:0] bm;
        exp_t e;
        stall[0] = 0; stall[1] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall[0] = 0; stall[1] = 0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    v  = (k == 0) ? out_valid_s : out_valid_h;
                    l  = (k == 0) ? out_last_s : out_last_h;
                    bm = (k == 0) ? bm_s : bm_h;
                    if (stall[k]) begin
                        chk(k == 0 ? "stall_valid_soft" : "stall_valid_hard", v, 1);
                        chk(k == 0 ? "stall_bm_soft" : "stall_bm_hard", bm, prev_bm[k]);
                        chk(k == 0 ? "stall_last_soft" : "stall_last_hard", l, prev_last[k]);
                    end
                    if (v && out_ready) begin
                        if ((k == 0 ? q_s.size() : q_h.size()) == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_output dut=%0d: bm %0h with empty queue", k, bm);
                        end else begin
                            e = (k == 0) ? q_s.pop_front() : q_h.pop_front();
                            chk(k == 0 ? "bm_soft" : "bm_hard", bm, e.bm);
                            chk(k == 0 ? "last_soft" : "last_hard", l, e.last);
                        end
                    end
                    stall[k] = v && !out_ready;
                    prev_bm[k] = bm; prev_last[k] = l;
                end
            end
        end
    end

    initial begin
        bit a, r;
        int idx, c;
        logic [5:0] ss [10];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_s, 0);
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_out_bm", bm_s, 0);
        chk("rst_out_last", out_last_s, 0);
        chk("rst_counts", {sc_s, ec_s}, 0);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", in_ready_s, 1);

        // Directed metrics: latency 2, soft values, erasure, hard decisions.
        step(1, {3'd6, 3'd2}, 2'b00, 0, 1, a, r);
        step(0, 6'd0, 2'b00, 0, 1, a, r);
        step(0, 6'd0, 2'b00, 0, 1, a, r);
        chk("t1_valid", out_valid_s, 1);
        chk("t1_bm", bm_s, 16'h63B8);
        step(1, {3'd6, 3'd2}, 2'b10, 0, 1, a, r);
        step(1, {3'd7, 3'd4}, 2'b00, 0, 1, a, r);
        step(0, 6'd0, 2'b00, 0, 1, a, r);
        chk("t2_bm", bm_s, 16'h5252);
        step(0, 6'd0, 2'b00, 0, 1, a, r);
        chk("t3_hard_bm", bm_h, 16'h0112);
        for (int p = 0; p < 4; p++)
            step(1, {p[1], 2'($urandom), p[0], 2'($urandom)}, 2'b00, 0, 1, a, r);

        // Stream of 10 with a 5-cycle output stall.
        for (int i = 0; i < 10; i++) ss[i] = 6'($urandom);
        idx = 0; c = 0;
        while (idx < 10 && c < 100) begin
            step(1, ss[idx], 2'b00, idx == 9, !(c >= 3 && c < 8), a, r);
            if (c >= 4 && c <= 7) chk("stall_in_ready", r, 0);
            if (a) idx++;
            c++;
        end
        if (idx != 10) begin checks++; errors++; $display("FAIL stream_accept: got %0d expected 10", idx); end

        // Frame of 5 then a back-to-back frame of 3.
        for (int i = 0; i < 8; i++) step(1, 6'($urandom), 2'($urandom), i == 4 || i == 7, 1, a, r);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 6'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, a, r);

        // Reset with branches in flight.
        step(1, 6'($urandom), 2'b01, 0, 1, a, r);
        step(1, 6'($urandom), 2'b00, 0, 1, a, r);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        q_s.delete(); q_h.delete();
        exp_sym = 0; exp_er = 0; clr_pend = 1'b0;
        #1 chk("rst_mid_in_ready", in_ready_s, 0);
        @(posedge clk); #1;
        chk("rst_mid_out_valid", out_valid_s, 0);
        chk("rst_mid_counts", {sc_s, ec_s}, 0);
        rst = 1'b0;
        #1 chk("rst_mid_in_ready_after", in_ready_s, 1);
        for (int i = 0; i < 5; i++) step(0, 6'd0, 2'b00, 0, 1, a, r);
        for (int i = 0; i < 6; i++) step(1, 6'($urandom), 2'($urandom), i == 5, 1, a, r);

        c = 0;
        while ((q_s.size() != 0 || q_h.size() != 0) && c < 50) begin
            step(0, 6'd0, 2'b00, 0, 1, a, r);
            c++;
        end
        chk("drain_soft", q_s.size(), 0);
        chk("drain_hard", q_h.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
